multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through FETCH / DECODE / EXECUTE / MEM / WRITEBACK and drives per-state datapath strobes.
- Waits on a memory ready handshake, with a wait-state timeout.
- Sits between instruction register opcode field, shared instruction/data memory port, register file, ALU and PC logic.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 30 +++
 rtl/multicycle_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, ALU codes, mux selects and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SUBI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ANDI  = 6'b101111;
    localparam logic [5:0] OP_ORI   = 6'b110010;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_ADDI  = 4'b0010;
    localparam logic [3:0] ALU_SUBI  = 4'b0011;
    localparam logic [3:0] ALU_ANDI  = 4'b0101;
    localparam logic [3:0] ALU_ORI   = 4'b0111;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;

    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM,
        WRITEBACK, BRANCH, JUMP, FAULT
    } state_t;

    typedef enum logic [3:0] {
        C_LW, C_SW, C_ADDI, C_SUBI, C_ANDI, C_ORI,
        C_BEQ, C_BNE, C_J, C_RTYPE, C_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts consecutive not-ready memory cycles; flags the cycle on
// which the wait limit is reached while memory is still not ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = waiting && !ready
                   && (cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (waiting && !ready && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction through
// fetch/decode/execute/mem/writeback and drives datapath strobes.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                pc_write_cond_ne,
    output logic [1:0]          pc_src,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mdr_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                fault
);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    op_class_t           cls_q;
    op_class_t           cls_in;
    logic                waiting;
    logic                expired;

    function automatic op_class_t classify(
        input logic [OPCODE_W-1:0] op
    );
        case (op)
            OPCODE_W'(OP_LW):    return C_LW;
            OPCODE_W'(OP_SW):    return C_SW;
            OPCODE_W'(OP_ADDI):  return C_ADDI;
            OPCODE_W'(OP_SUBI):  return C_SUBI;
            OPCODE_W'(OP_ANDI):  return C_ANDI;
            OPCODE_W'(OP_ORI):   return C_ORI;
            OPCODE_W'(OP_BEQ):   return C_BEQ;
            OPCODE_W'(OP_BNE):   return C_BNE;
            OPCODE_W'(OP_J):     return C_J;
            OPCODE_W'(OP_RTYPE): return C_RTYPE;
            default:             return C_ILLEGAL;
        endcase
    endfunction

    assign cls_in  = classify(opcode);
    assign cls_q   = classify(op_q);
    assign waiting = (state == FETCH) || (state == MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .ready  (mem_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            op_q  <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_ready)    state <= DECODE;
                    else if (expired) state <= FAULT;
                end
                DECODE: begin
                    op_q <= opcode;
                    unique case (cls_in)
                        C_J:          state <= JUMP;
                        C_BEQ, C_BNE: state <= BRANCH;
                        C_ILLEGAL:    state <= FETCH;
                        default:      state <= EXECUTE;
                    endcase
                end
                EXECUTE: begin
                    if (cls_q == C_LW || cls_q == C_SW)
                        state <= MEM;
                    else
                        state <= WRITEBACK;
                end
                MEM: begin
                    if (mem_ready)
                        state <= (cls_q == C_LW) ? WRITEBACK : FETCH;
                    else if (expired)
                        state <= FAULT;
                end
                WRITEBACK, BRANCH, JUMP: state <= FETCH;
                FAULT:                   state <= FAULT;
            endcase
        end
    end

    // Gated by rst so strobes drop the instant reset is asserted.
    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_write_cond_ne = 1'b0;
        pc_src           = PC_SRC_ALU;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mdr_write        = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRC_B_REG;
        alu_op           = ALU_OP_W'(ALU_ADD);
        instr_done       = 1'b0;
        illegal_op       = 1'b0;
        fault            = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = SRC_B_IMM_SH;
                    illegal_op = (cls_in == C_ILLEGAL);
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    case (cls_q)
                        C_ADDI:  alu_op = ALU_OP_W'(ALU_ADDI);
                        C_SUBI:  alu_op = ALU_OP_W'(ALU_SUBI);
                        C_ANDI:  alu_op = ALU_OP_W'(ALU_ANDI);
                        C_ORI:   alu_op = ALU_OP_W'(ALU_ORI);
                        C_RTYPE: begin
                            alu_src_b = SRC_B_REG;
                            alu_op    = ALU_OP_W'(ALU_RTYPE);
                        end
                        default: alu_op = ALU_OP_W'(ALU_ADD);
                    endcase
                end
                MEM: begin
                    i_or_d = 1'b1;
                    if (cls_q == C_LW) begin
                        mem_read  = 1'b1;
                        mdr_write = mem_ready;
                    end else begin
                        mem_write  = 1'b1;
                        instr_done = mem_ready;
                    end
                end
                WRITEBACK: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    mem_to_reg = (cls_q == C_LW);
                    reg_dst    = (cls_q == C_RTYPE);
                end
                BRANCH: begin
                    alu_src_a        = 1'b1;
                    alu_op           = ALU_OP_W'(ALU_SUB);
                    pc_src           = PC_SRC_ALUOUT;
                    instr_done       = 1'b1;
                    pc_write_cond    = (cls_q == C_BEQ);
                    pc_write_cond_ne = (cls_q == C_BNE);
                end
                JUMP: begin
                    pc_src     = PC_SRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                FAULT: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit: one row
// per clock cycle with hand-computed strobe vectors.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       fault;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       rdy;
        outs_t      exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, pc_write_cond_ne;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, ir_write, mdr_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done, illegal_op, fault;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    multicycle_control_unit #(
        .OPCODE_W(6), .ALU_OP_W(4), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_write_cond_ne(pc_write_cond_ne), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_done(instr_done),
        .illegal_op(illegal_op), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic outs_t e_zero();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t e_fetch(input logic r);
        outs_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'd1;
        o.ir_write = r; o.pc_write = r;
        return o;
    endfunction

    function automatic outs_t e_dec(input logic ill);
        outs_t o = '0;
        o.alu_src_b = 2'd3; o.illegal_op = ill;
        return o;
    endfunction

    function automatic outs_t e_exec(input logic [1:0] sb,
                                     input logic [3:0] op);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = sb; o.alu_op = op;
        return o;
    endfunction

    function automatic outs_t e_mem_lw(input logic r);
        outs_t o = '0;
        o.i_or_d = 1'b1; o.mem_read = 1'b1; o.mdr_write = r;
        return o;
    endfunction

    function automatic outs_t e_mem_sw(input logic r);
        outs_t o = '0;
        o.i_or_d = 1'b1; o.mem_write = 1'b1; o.instr_done = r;
        return o;
    endfunction

    function automatic outs_t e_wb(input logic m2r, input logic rd);
        outs_t o = '0;
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        o.mem_to_reg = m2r; o.reg_dst = rd;
        return o;
    endfunction

    function automatic outs_t e_br(input logic ne);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 4'b0001; o.pc_src = 2'd1;
        o.instr_done = 1'b1;
        o.pc_write_cond = !ne; o.pc_write_cond_ne = ne;
        return o;
    endfunction

    function automatic outs_t e_jump();
        outs_t o = '0;
        o.pc_src = 2'd2; o.pc_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic outs_t e_fault();
        outs_t o = '0;
        o.fault = 1'b1;
        return o;
    endfunction

    function automatic void add(input logic r, input logic [5:0] op,
                                input logic rdy, input outs_t e,
                                input string nm);
        vec_t v;
        v.rst = r; v.opc = op; v.rdy = rdy; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        outs_t act;
        @(negedge clk);
        rst = v.rst; opcode = v.opc; mem_ready = v.rdy;
        #1;
        act = {pc_write, pc_write_cond, pc_write_cond_ne, pc_src,
               i_or_d, mem_read, mem_write, ir_write, mdr_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, fault};
        n_vec++;
        if (act !== v.exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", v.name, act, v.exp);
        end
    endtask

    localparam logic [5:0] X = 6'b111111;

    initial begin
        // reset
        add(1, 0, 0, e_zero(), "reset0");
        add(1, 0, 1, e_zero(), "reset1");
        // LW, no waits; IR junk after DECODE must be ignored
        add(0, X, 1, e_fetch(1), "lw_fetch");
        add(0, 6'b100011, 1, e_dec(0), "lw_dec");
        add(0, X, 1, e_exec(2, 4'b0000), "lw_exec");
        add(0, X, 1, e_mem_lw(1), "lw_mem");
        add(0, X, 1, e_wb(1, 0), "lw_wb");
        // SW with 3 MEM wait states
        add(0, X, 1, e_fetch(1), "sw_fetch");
        add(0, 6'b101011, 1, e_dec(0), "sw_dec");
        add(0, X, 1, e_exec(2, 4'b0000), "sw_exec");
        for (int i = 0; i < 3; i++)
            add(0, X, 0, e_mem_sw(0), "sw_mem_wait");
        add(0, X, 1, e_mem_sw(1), "sw_mem_done");
        // RTYPE with one fetch wait
        add(0, X, 0, e_fetch(0), "rt_fetch_wait");
        add(0, X, 1, e_fetch(1), "rt_fetch");
        add(0, 6'b000000, 1, e_dec(0), "rt_dec");
        add(0, X, 1, e_exec(0, 4'b1111), "rt_exec");
        add(0, X, 1, e_wb(0, 1), "rt_wb");
        // ADDI
        add(0, X, 1, e_fetch(1), "addi_fetch");
        add(0, 6'b001000, 1, e_dec(0), "addi_dec");
        add(0, X, 1, e_exec(2, 4'b0010), "addi_exec");
        add(0, X, 1, e_wb(0, 0), "addi_wb");
        // ORI
        add(0, X, 1, e_fetch(1), "ori_fetch");
        add(0, 6'b110010, 1, e_dec(0), "ori_dec");
        add(0, X, 1, e_exec(2, 4'b0111), "ori_exec");
        add(0, X, 1, e_wb(0, 0), "ori_wb");
        // SUBI, ANDI
        add(0, X, 1, e_fetch(1), "subi_fetch");
        add(0, 6'b100111, 1, e_dec(0), "subi_dec");
        add(0, X, 1, e_exec(2, 4'b0011), "subi_exec");
        add(0, X, 1, e_wb(0, 0), "subi_wb");
        add(0, X, 1, e_fetch(1), "andi_fetch");
        add(0, 6'b101111, 1, e_dec(0), "andi_dec");
        add(0, X, 1, e_exec(2, 4'b0101), "andi_exec");
        add(0, X, 1, e_wb(0, 0), "andi_wb");
        // BNE, BEQ, J
        add(0, X, 1, e_fetch(1), "bne_fetch");
        add(0, 6'b000101, 1, e_dec(0), "bne_dec");
        add(0, X, 1, e_br(1), "bne_branch");
        add(0, X, 1, e_fetch(1), "beq_fetch");
        add(0, 6'b000100, 1, e_dec(0), "beq_dec");
        add(0, 6'b000101, 1, e_br(0), "beq_branch");
        add(0, X, 1, e_fetch(1), "j_fetch");
        add(0, 6'b000010, 1, e_dec(0), "j_dec");
        add(0, X, 1, e_jump(), "j_jump");
        // illegal opcode: 2 cycles then FETCH
        add(0, 0, 1, e_fetch(1), "ill_fetch");
        add(0, X, 1, e_dec(1), "ill_dec");
        add(0, 0, 0, e_fetch(0), "ill_refetch");
        // reset while LW waits in MEM
        add(0, X, 1, e_fetch(1), "rlw_fetch");
        add(0, 6'b100011, 1, e_dec(0), "rlw_dec");
        add(0, X, 1, e_exec(2, 4'b0000), "rlw_exec");
        add(0, X, 0, e_mem_lw(0), "rlw_mem_wait");
        add(1, X, 1, e_zero(), "rlw_rst_mid");
        add(0, X, 0, e_fetch(0), "rlw_post_fetch");
        add(0, X, 1, e_fetch(1), "rlw_next_fetch");
        add(0, 6'b001000, 1, e_dec(0), "rlw_next_dec");
        add(0, X, 1, e_exec(2, 4'b0010), "rlw_next_exec");
        add(0, X, 1, e_wb(0, 0), "rlw_next_wb");

        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();

        // ready arriving exactly on the limit cycle wins
        for (int i = 0; i < 15; i++)
            add(0, X, 0, e_fetch(0), "tob_wait");
        add(0, X, 1, e_fetch(1), "tob_ready_on_limit");
        add(0, 6'b000010, 0, e_dec(0), "tob_dec");
        add(0, X, 0, e_jump(), "tob_jump");
        // a 16th consecutive not-ready cycle trips the fault
        for (int i = 0; i < 16; i++)
            add(0, X, 0, e_fetch(0), "to_wait");
        add(0, X, 0, e_fault(), "to_fault");
        add(0, X, 1, e_fault(), "to_fault_sticky_rdy");
        add(0, 6'b100011, 1, e_fault(), "to_fault_sticky");
        add(1, X, 0, e_zero(), "to_rst");
        add(0, X, 1, e_fetch(1), "to_recover_fetch");
        add(0, 6'b000100, 1, e_dec(0), "to_recover_dec");
        add(0, X, 1, e_br(0), "to_recover_branch");

        foreach (tbl[i]) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
